// File: rtl/fifo_2w_wr_arbiter.sv
// Round-robin write-side arbiter for a 2-write/1-read sync FIFO.
// Up to two valid requesters win per cycle. The first winner always drives
// port 0 and the second drives port 1. Each requester has a saturating
// counter of accepted transfers.
module fifo_2w_wr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en0,
  output logic                     fifo_wr_en1,
  output logic [WIDTH-1:0]         fifo_datain0,
  output logic [WIDTH-1:0]         fifo_datain1,
  input  logic                     cnt_clr,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W-1:0] rr_ptr_next;
  logic [PTR_W-1:0] g0;
  logic [PTR_W-1:0] g1;
  logic             found0;
  logic             found1;
  logic [PTR_W:0]   idx;
  logic             grant_ok;

  // The next index after p, wrapping at NUM_REQ-1 even when NUM_REQ is
  // not a power of two.
  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] p);
    if (p == LAST_IDX) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign grant_ok = arb_en & ~fifo_full;

  // Scan from rr_ptr upward (mod NUM_REQ) and record the first two valid indices.
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    g0     = '0;
    g1     = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
      if (idx >= NUM_REQ_X) begin
        idx = idx - NUM_REQ_X;
      end
      if (req_valid[idx[PTR_W-1:0]]) begin
        if (!found0) begin
          found0 = 1'b1;
          g0     = idx[PTR_W-1:0];
        end else if (!found1) begin
          found1 = 1'b1;
          g1     = idx[PTR_W-1:0];
        end
      end
    end
  end

  // Drive the grants and FIFO ports. All outputs are zero while paused or full.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en0  = 1'b0;
    fifo_wr_en1  = 1'b0;
    fifo_datain0 = '0;
    fifo_datain1 = '0;
    if (grant_ok && found0) begin
      req_ready[g0] = 1'b1;
      fifo_wr_en0   = 1'b1;
      fifo_datain0  = req_data[int'(g0)*WIDTH +: WIDTH];
      if (found1) begin
        req_ready[g1] = 1'b1;
        fifo_wr_en1   = 1'b1;
        fifo_datain1  = req_data[int'(g1)*WIDTH +: WIDTH];
      end
    end
  end

  // Priority moves just past the last winner. It holds when nothing is granted.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_ok && found1) begin
      rr_ptr_next = inc_wrap(g1);
    end else if (grant_ok && found0) begin
      rr_ptr_next = inc_wrap(g0);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Count accepted transfers. Clear wins over an increment in the same
      // cycle, and the counter sticks at all-ones.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (cnt_clr) begin
          cnt_reg <= '0;
        end else if (req_valid[gi] && req_ready[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_2w_wr_arbiter.sv
// Directed bench for fifo_2w_wr_arbiter (NUM_REQ=4, WIDTH=32, CNT_W=2).
module tb_fifo_2w_wr_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     arb_en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en0;
  logic                     fifo_wr_en1;
  logic [WIDTH-1:0]         fifo_datain0;
  logic [WIDTH-1:0]         fifo_datain1;
  logic                     cnt_clr;
  logic [NUM_REQ*CNT_W-1:0] grant_cnt;

  int n_compared;
  int n_mismatched;

  fifo_2w_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (arb_en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en0 (fifo_wr_en0),
    .fifo_wr_en1 (fifo_wr_en1),
    .fifo_datain0(fifo_datain0),
    .fifo_datain1(fifo_datain1),
    .cnt_clr     (cnt_clr),
    .grant_cnt   (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] D0 = 32'hA000_0000;
  localparam logic [31:0] D1 = 32'hA111_1111;
  localparam logic [31:0] D2 = 32'hA222_2222;
  localparam logic [31:0] D3 = 32'hA333_3333;

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check every grant-side output against hand-computed values.
  task automatic check_grant(input string tag, input logic [3:0] rdy, input logic we0, input logic we1,
                             input logic [31:0] d0, input logic [31:0] d1);
    #1;
    check_eq({tag, ".ready"}, 64'(req_ready), 64'(rdy));
    check_eq({tag, ".wr_en"}, 64'({fifo_wr_en1, fifo_wr_en0}), 64'({we1, we0}));
    check_eq({tag, ".din0"}, 64'(fifo_datain0), 64'(d0));
    check_eq({tag, ".din1"}, 64'(fifo_datain1), 64'(d1));
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n     = 1'b0;
    arb_en    = 1'b1;
    fifo_full = 1'b0;
    cnt_clr   = 1'b0;
    req_valid = 4'b0000;
    req_data  = {D3, D2, D1, D0};

    // Reset state with no requester valid.
    step();
    step();
    check_grant("reset_idle", 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("reset_cnt", 64'(grant_cnt), 64'h0);
    rst_n = 1'b1;

    // Test 1: all valid, pairs 0/1 then 2/3 then 0/1.
    req_valid = 4'b1111;
    check_grant("t1_c0", 4'b0011, 1'b1, 1'b1, D0, D1);
    step();
    check_grant("t1_c1", 4'b1100, 1'b1, 1'b1, D2, D3);
    step();
    check_grant("t1_c2", 4'b0011, 1'b1, 1'b1, D0, D1);
    step();
    // ptr=2; counts: r0=2 r1=2 r2=1 r3=1
    check_eq("t1_cnt", 64'(grant_cnt), 64'({2'd1, 2'd1, 2'd2, 2'd2}));

    // Move the pointer to 0 with a single grant of requester 3.
    req_valid = 4'b1000;
    check_grant("move_ptr", 4'b1000, 1'b1, 1'b0, D3, 32'h0);
    step();

    // Test 2: only requester 2 valid with ptr=0.
    req_valid = 4'b0100;
    check_grant("t2_single", 4'b0100, 1'b1, 1'b0, D2, 32'h0);
    step();

    // Test 3: ptr=3, requesters 3 and 0 valid -> wrap.
    req_valid = 4'b1001;
    check_grant("t3_wrap", 4'b1001, 1'b1, 1'b1, D3, D0);
    step();
    // ptr=1; counts: r0=3 r1=2 r2=2 r3=3
    check_eq("t3_cnt", 64'(grant_cnt), 64'({2'd3, 2'd2, 2'd2, 2'd3}));

    // Test 4: full blocks everything. Pointer and counters hold.
    req_valid = 4'b1111;
    fifo_full = 1'b1;
    check_grant("t4_full", 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_eq("t4_cnt_hold", 64'(grant_cnt), 64'({2'd3, 2'd2, 2'd2, 2'd3}));
    fifo_full = 1'b0;
    check_grant("t4_resume", 4'b0110, 1'b1, 1'b1, D1, D2);
    step();
    // ptr=3. A pause holds the pointer too.
    arb_en = 1'b0;
    check_grant("pause", 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    arb_en = 1'b1;
    check_grant("pause_resume", 4'b1001, 1'b1, 1'b1, D3, D0);
    step();
    // ptr=1; all counters saturated at 3.
    check_eq("sat_all", 64'(grant_cnt), 64'hFF);

    // Test 5: clear wins over a same-cycle grant.
    cnt_clr = 1'b1;
    check_grant("clr_grant", 4'b0110, 1'b1, 1'b1, D1, D2);
    step();
    cnt_clr = 1'b0;
    check_eq("clr_cnt", 64'(grant_cnt), 64'h0);
    // ptr=3. Requester 0 alone, five grants -> saturates at 3.
    req_valid = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      check_grant($sformatf("t5_g%0d", i), 4'b0001, 1'b1, 1'b0, D0, 32'h0);
      step();
      check_eq($sformatf("t5_cnt%0d", i), 64'(grant_cnt), 64'((i > 3) ? 3 : i));
    end
    // No valid requester means all outputs are zero.
    req_valid = 4'b0000;
    check_grant("no_valid", 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);

    // Test 6: ptr=1 -> grant 1 alone to reach ptr=2, then reset mid-stream.
    req_valid = 4'b0010;
    check_grant("t6_single", 4'b0010, 1'b1, 1'b0, D1, 32'h0);
    step();
    req_valid = 4'b1111;
    check_grant("t6_ptr2", 4'b1100, 1'b1, 1'b1, D2, D3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_cnt", 64'(grant_cnt), 64'h0);
    check_grant("t6_in_rst", 4'b0011, 1'b1, 1'b1, D0, D1);
    step();
    rst_n = 1'b1;
    check_grant("t6_after", 4'b0011, 1'b1, 1'b1, D0, D1);
    step();
    check_eq("t6_cnt", 64'(grant_cnt), 64'({2'd0, 2'd0, 2'd1, 2'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
